// File: rtl/eth_fcs_check.sv
// Receive-side Ethernet FCS checker: feeds nibbles to an external crc32_4bit, strips the 4-byte FCS, flags bad/runt frames.
// Latency: CRC feed and payload out are one register stage (payload nibble k leaves the cycle after nibble k+8 arrives); done/kill two cycles after the last nibble.
// Backpressure: none; input is a contiguous valid stream; a frame arriving before the previous verdict completes is dropped whole.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   axiiv, axiid          input nibble stream (preamble/SFD removed, FCS included), MSB-first bits
//   crc_en, crc_data      registered feed to the engine's crc_en / data_in
//   crc_clr               one-cycle engine clear in the verdict cycle (engine rst = rst | crc_clr)
//   crc_out_en, crc_out   engine valid (debug only) and CRC register
//   axiov, axiod          payload nibble stream with the trailing 8 FCS nibbles removed
//   done, kill            one-cycle end-of-frame pulse; kill (valid with done) = bad FCS or runt
module eth_fcs_check #(
   parameter int unsigned MIN_NIBBLES = 128,
   parameter logic [31:0] RESIDUE     = 32'h38FB2284
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        axiiv,
   input  logic [3:0]  axiid,
   output logic        crc_en,
   output logic [3:0]  crc_data,
   output logic        crc_clr,
   input  logic        crc_out_en,
   input  logic [31:0] crc_out,
   output logic        axiov,
   output logic [3:0]  axiod,
   output logic        done,
   output logic        kill
);

   localparam logic [11:0] MIN_CNT = 12'(MIN_NIBBLES);

   // The cycle RECV spends observing axiiv low is the engine's absorb slot for
   // the last registered nibble, so RECV exits straight to the verdict state.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_CHECK = 2'd2,
      S_DROP  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [11:0]      len_cnt;
   logic [7:0][3:0]  strip_sr;
   logic [3:0]       fill;
   logic             accept;

   // Engine valid is only of interest on a debug probe.
   logic unused_crc_out_en;
   assign unused_crc_out_en = crc_out_en;

   // Nibbles are only taken while a frame is (or may start) being received;
   // DROP and the verdict cycle never feed the engine or the payload path.
   assign accept = axiiv && ((state == S_IDLE) || (state == S_RECV));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         len_cnt  <= '0;
         strip_sr <= '0;
         fill     <= '0;
         crc_en   <= 1'b0;
         crc_data <= '0;
         axiov    <= 1'b0;
         axiod    <= '0;
      end else begin
         state    <= state_nxt;
         crc_en   <= accept;
         crc_data <= accept ? axiid : 4'h0;
         axiov    <= 1'b0;

         if (accept) begin
            if (state == S_IDLE) begin
               // First nibble of a frame: restart length and strip buffer.
               len_cnt  <= 12'd1;
               strip_sr <= {28'h0, axiid};
               fill     <= 4'd1;
            end else begin
               if (len_cnt != 12'hFFF)
                  len_cnt <= len_cnt + 12'd1;
               // With 8 nibbles held, the oldest can no longer be FCS.
               if (fill == 4'd8) begin
                  axiov <= 1'b1;
                  axiod <= strip_sr[7];
               end else begin
                  fill <= fill + 4'd1;
               end
               strip_sr <= {strip_sr[6:0], axiid};
            end
         end else if (state == S_IDLE) begin
            strip_sr <= '0;
            fill     <= '0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      kill      = 1'b0;
      crc_clr   = 1'b0;
      case (state)
         S_IDLE: begin
            if (axiiv)
               state_nxt = S_RECV;
         end
         S_RECV: begin
            if (!axiiv)
               state_nxt = S_CHECK;
         end
         S_CHECK: begin
            done    = 1'b1;
            crc_clr = 1'b1;
            kill    = (crc_out != RESIDUE) || (len_cnt < MIN_CNT);
            // A frame starting inside the gap is missing its head: drop it.
            state_nxt = axiiv ? S_DROP : S_IDLE;
         end
         S_DROP: begin
            if (!axiiv)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_eth_fcs_check.sv
// Directed bench for eth_fcs_check with a bit-serial CRC-32 engine model standing in for crc32_4bit.
// Latency checked: crc_en the cycle after the last nibble, done/kill/crc_clr one cycle later.
// Backpressure: none; frames are driven as contiguous valid streams.
module tb_eth_fcs_check;

   localparam logic [31:0] RES = 32'h38FB2284;

   logic        clk = 1'b0;
   logic        rst;
   logic        axiiv;
   logic [3:0]  axiid;
   logic        crc_en;
   logic [3:0]  crc_data;
   logic        crc_clr;
   logic        crc_out_en;
   logic [31:0] crc_out;
   logic        axiov;
   logic [3:0]  axiod;
   logic        done;
   logic        kill;

   always #5 clk = ~clk;

   eth_fcs_check #(.MIN_NIBBLES(16), .RESIDUE(RES)) dut (
      .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
      .crc_en(crc_en), .crc_data(crc_data), .crc_clr(crc_clr),
      .crc_out_en(crc_out_en), .crc_out(crc_out),
      .axiov(axiov), .axiod(axiod), .done(done), .kill(kill)
   );

   // MSB-first CRC-32, init all-ones, complemented output; a frame carrying
   // the complemented register as FCS leaves the output at 0x38FB2284.
   function automatic logic [31:0] crc_step(input logic [31:0] r, input logic [3:0] n);
      logic [31:0] c;
      logic        fb;
      c = r;
      for (int b = 3; b >= 0; b--) begin
         fb = c[31] ^ n[b];
         c  = {c[30:0], 1'b0};
         if (fb) c = c ^ 32'h04C11DB7;
      end
      return c;
   endfunction

   logic [31:0] eng;
   always @(posedge clk) begin
      if (rst || crc_clr) eng <= 32'hFFFFFFFF;
      else if (crc_en)    eng <= crc_step(eng, crc_data);
      crc_out_en <= rst ? 1'b0 : crc_en;
   end
   assign crc_out = ~eng;

   // Output monitor, sampled on the falling edge.
   logic [3:0]  pay[$];
   int          done_cnt = 0;
   logic        last_kill = 1'b0;
   logic [31:0] last_crc = '0;
   always @(negedge clk) begin
      if (axiov) pay.push_back(axiod);
      if (done) begin
         done_cnt++;
         last_kill = kill;
         last_crc  = crc_out;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [3:0] frm[$];

   task automatic make_good(input logic [63:0] p, input int n);
      logic [31:0] r;
      logic [31:0] f;
      frm.delete();
      r = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         frm.push_back(p[4*(n-1-i) +: 4]);
         r = crc_step(r, p[4*(n-1-i) +: 4]);
      end
      f = ~r;
      for (int k = 7; k >= 0; k--) frm.push_back(f[4*k +: 4]);
   endtask

   // Presents frm[from..to-1] one nibble per cycle; returns 1 ns into the
   // first cycle after the last nibble with axiiv low.
   task automatic feed(input int from, input int to);
      for (int i = from; i < to; i++) begin
         axiiv = 1'b1;
         axiid = frm[i];
         @(posedge clk); #1;
      end
      axiiv = 1'b0;
      axiid = 4'h0;
   endtask

   // Called at t+1: checks the last feed, then the verdict cycle, then the return to idle.
   task automatic end_check(input string tag, input logic ek);
      check({tag, "_crc_en_t1"}, 64'(crc_en), 64'd1);
      check({tag, "_done_t1"}, 64'(done), 64'd0);
      @(posedge clk); #1;
      check({tag, "_done_t2"}, 64'(done), 64'd1);
      check({tag, "_kill_t2"}, 64'(kill), 64'(ek));
      check({tag, "_clr_t2"}, 64'(crc_clr), 64'd1);
      check({tag, "_axiov_t2"}, 64'(axiov), 64'd0);
      @(posedge clk); #1;
      check({tag, "_done_t3"}, 64'(done), 64'd0);
   endtask

   function automatic logic [63:0] packed_pay(input int from, input int n);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v = (v << 4) | 64'(pay[from + i]);
      return v;
   endfunction

   int base;
   int dbase;

   initial begin
      rst   = 1'b1;
      axiiv = 1'b0;
      axiid = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_crc_en", 64'(crc_en), 64'd0);
      check("rst_crc_data", 64'(crc_data), 64'd0);
      check("rst_crc_clr", 64'(crc_clr), 64'd0);
      check("rst_axiov", 64'(axiov), 64'd0);
      check("rst_axiod", 64'(axiod), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_kill", 64'(kill), 64'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Good 24-nibble frame.
      base = pay.size(); dbase = done_cnt;
      make_good(64'h676960D19D785A5B, 16);
      feed(0, 24);
      check("good_last_data", 64'(crc_data), 64'(frm[23]));
      end_check("good", 1'b0);
      check("good_crc_out", 64'(last_crc), 64'(RES));
      check("good_pay_len", 64'(pay.size() - base), 64'd16);
      check("good_pay", packed_pay(base, 16), 64'h676960D19D785A5B);
      check("good_done_cnt", 64'(done_cnt - dbase), 64'd1);
      repeat (2) @(posedge clk);
      #1;

      // Same frame with nibble 3 corrupted.
      base = pay.size();
      frm[3] = 4'h8;
      feed(0, 24);
      end_check("bad", 1'b1);
      check("bad_pay_len", 64'(pay.size() - base), 64'd16);
      check("bad_pay", packed_pay(base, 16), 64'h676860D19D785A5B);
      repeat (2) @(posedge clk);
      #1;

      // Runt: 12 nibbles with a correct FCS is killed on length alone.
      base = pay.size();
      make_good(64'hABCD, 4);
      feed(0, 12);
      end_check("runt", 1'b1);
      check("runt_crc_out", 64'(last_crc), 64'(RES));
      check("runt_pay", packed_pay(base, 4), 64'hABCD);
      repeat (2) @(posedge clk);
      #1;

      // Back to back with a 2-cycle gap: both accepted.
      base = pay.size(); dbase = done_cnt;
      make_good(64'h676960D19D785A5B, 16);
      feed(0, 24);
      end_check("gap2_a", 1'b0);
      feed(0, 24);
      end_check("gap2_b", 1'b0);
      check("gap2_done_cnt", 64'(done_cnt - dbase), 64'd2);
      check("gap2_pay_len", 64'(pay.size() - base), 64'd32);
      repeat (2) @(posedge clk);
      #1;

      // Back to back with a 1-cycle gap: second frame dropped.
      base = pay.size(); dbase = done_cnt;
      feed(0, 24);
      @(posedge clk); #1;
      feed(0, 24);
      repeat (6) @(posedge clk);
      #1;
      check("gap1_done_cnt", 64'(done_cnt - dbase), 64'd1);
      check("gap1_kill", 64'(last_kill), 64'd0);
      check("gap1_pay_len", 64'(pay.size() - base), 64'd16);

      // Reset while nibble 9 is presented; nibbles 10..23 become a new frame.
      base = pay.size(); dbase = done_cnt;
      feed(0, 9);
      axiiv = 1'b1;
      axiid = frm[9];
      rst   = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      axiid = frm[10];
      check("mid_rst_crc_en", 64'(crc_en), 64'd0);
      check("mid_rst_axiov", 64'(axiov), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_kill", 64'(kill), 64'd0);
      check("mid_rst_clr", 64'(crc_clr), 64'd0);
      feed(10, 24);
      end_check("mid_rst_tail", 1'b1);
      check("mid_rst_pay_len", 64'(pay.size() - base), 64'd7);
      repeat (2) @(posedge clk);
      #1;
      feed(0, 24);
      end_check("after_rst", 1'b0);
      check("after_rst_done_cnt", 64'(done_cnt - dbase), 64'd2);
      repeat (2) @(posedge clk);
      #1;

      // FCS-only frame.
      base = pay.size();
      make_good(64'h0, 0);
      feed(0, 8);
      end_check("fcs_only", 1'b1);
      check("fcs_only_pay_len", 64'(pay.size() - base), 64'd0);
      repeat (2) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
